// File: rtl/m65_kbd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : m65_kbd_pkg
//  Description : Shared types and constants for the MEGA65 matrix to PS/2
//                set-2 scancode translator: key count, MEGA key index, the
//                72-entry scancode table and the queued event record.
//  Revision    : 1.0 - initial release
// ============================================================================
package m65_kbd_pkg;

    localparam int NUM_KEYS     = 72;
    localparam int MEGA_KEY_IDX = 61;

    // One queued key event. Field order is also the FIFO storage layout.
    typedef struct packed {
        logic       ext;       // code needs an E0 prefix
        logic [6:0] code;      // set-2 code, low 7 bits
        logic       released;  // 1 = break, 0 = make
    } kbd_event_t;

    // Table entry as stored in SCAN_TABLE.
    typedef struct packed {
        logic       mapped;
        logic       ext;
        logic [6:0] code;
    } scan_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } emit_state_t;

    // {mapped, ext, code[6:0]}: 9'h1xx = plain code xx, 9'h18x/9'h1Fx = E0
    // prefixed, 9'h000 = no PS/2 equivalent. Codes that need bit 7
    // (F7 = 0x83) cannot be represented and are left unmapped.
    localparam logic [8:0] SCAN_TABLE [NUM_KEYS] = '{
        // DEL    RETURN  CRSR-R  F7      F1      F3      F5      CRSR-D
        9'h166, 9'h15A, 9'h1F4, 9'h000, 9'h105, 9'h104, 9'h103, 9'h1F2,
        // 3      W       A       4       Z       S       E       LSHIFT
        9'h126, 9'h11D, 9'h11C, 9'h125, 9'h11A, 9'h11B, 9'h124, 9'h112,
        // 5      R       D       6       C       F       T       X
        9'h12E, 9'h12D, 9'h123, 9'h136, 9'h121, 9'h12B, 9'h12C, 9'h122,
        // 7      Y       G       8       B       H       U       V
        9'h13D, 9'h135, 9'h134, 9'h13E, 9'h132, 9'h133, 9'h13C, 9'h12A,
        // 9      I       J       0       M       K       O       N
        9'h146, 9'h143, 9'h13B, 9'h145, 9'h13A, 9'h142, 9'h144, 9'h131,
        // +      P       L       -       .       :       @       ,
        9'h155, 9'h14D, 9'h14B, 9'h14E, 9'h149, 9'h14C, 9'h154, 9'h141,
        // POUND  *       ;       HOME    RSHIFT  =       UP-ARR  /
        9'h000, 9'h15B, 9'h152, 9'h1EC, 9'h159, 9'h15D, 9'h000, 9'h14A,
        // 1      <-      CTRL    2       SPACE   MEGA    Q       RUN/STOP
        9'h116, 9'h10E, 9'h114, 9'h11E, 9'h129, 9'h000, 9'h115, 9'h176,
        // NOSCRL TAB     ALT     HELP    F9      F11     F13     ESC
        9'h17E, 9'h10D, 9'h111, 9'h000, 9'h101, 9'h178, 9'h000, 9'h176
    };

    // Out-of-range indices read back as an unmapped entry.
    function automatic scan_entry_t scan_lookup(input logic [6:0] idx);
        scan_entry_t entry;
        entry = '0;
        if (idx < 7'(NUM_KEYS)) begin
            entry = scan_entry_t'(SCAN_TABLE[idx]);
        end
        return entry;
    endfunction

endpackage : m65_kbd_pkg
`default_nettype wire

// File: rtl/m65_kbd_event_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : m65_kbd_event_fifo
//  Description : Synchronous show-ahead FIFO for key events. A push into a
//                full FIFO is accepted only when a pop happens on the same
//                edge; a push into an empty FIFO is not visible at o_head
//                until the following cycle.
//  Ports       : clk, rst_n (async active-low)
//                i_push/i_push_data  write side
//                i_pop               read side, o_head = oldest entry
//                o_full/o_empty      occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module m65_kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int             c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_depth);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule : m65_kbd_event_fifo
`default_nettype wire

// File: rtl/m65_matrix_to_scancode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : m65_matrix_to_scancode
//  Description : Tracks MEGA65 key-matrix state, turns each state change of
//                a mapped key into a PS/2 set-2 make/break event, queues it
//                and emits queued events one at a time with a minimum
//                spacing of GAP_CYCLES between scan_received pulses.
//  Ports       : clk, rst_n (async assert, sync release internally)
//                matrix_valid/matrix_idx/matrix_pressed  key change strobe
//                scan_received/scan/extended/released    emitted event
//                mega_pressed  live MEGA key level
//                overflow      sticky, an event was dropped on a full FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module m65_matrix_to_scancode #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       matrix_valid,
    input  logic [6:0] matrix_idx,
    input  logic       matrix_pressed,
    output logic       scan_received,
    output logic [6:0] scan,
    output logic       extended,
    output logic       released,
    output logic       mega_pressed,
    output logic       overflow
);

    import m65_kbd_pkg::*;

    localparam int               c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_gap_w-1:0] c_gap_init = c_gap_w'(GAP_CYCLES - 1);
    localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);
    localparam logic [6:0]       c_num_keys = 7'(NUM_KEYS);
    localparam logic [6:0]       c_mega_idx = 7'(MEGA_KEY_IDX);

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion passes straight through, release is
    // delayed two rising edges so no flop sees it near the clock edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Key state and event generation
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] r_key_state;
    logic                r_overflow;
    scan_entry_t         w_entry;
    logic                w_idx_ok;
    logic                w_changed;
    logic                w_push;
    kbd_event_t          w_push_ev;

    assign w_entry   = scan_lookup(matrix_idx);
    assign w_idx_ok  = (matrix_idx < c_num_keys);
    assign w_changed = matrix_valid && w_idx_ok &&
                       (r_key_state[matrix_idx] != matrix_pressed);
    // The MEGA key only drives mega_pressed; it never becomes an event.
    assign w_push    = w_changed && w_entry.mapped && (matrix_idx != c_mega_idx);
    assign w_push_ev = '{ext: w_entry.ext, code: w_entry.code, released: ~matrix_pressed};

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [$bits(kbd_event_t)-1:0] w_fifo_head;
    kbd_event_t               w_head;

    m65_kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(kbd_event_t))
    ) u_event_fifo (
        .clk         (clk),
        .rst_n       (w_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_ev),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign w_head = kbd_event_t'(w_fifo_head);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key_state <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_changed) begin
                r_key_state[matrix_idx] <= matrix_pressed;
            end
            // Dropped only when no pop frees a slot on the same edge.
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Emitter: IDLE pops and loads, EMIT is the pulse cycle, GAP spaces
    // pulses out. Output fields hold until the next load.
    // ------------------------------------------------------------------
    emit_state_t        r_state;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic               r_scan_received;
    logic [6:0]         r_scan;
    logic               r_extended;
    logic               r_released;

    assign w_pop = (r_state == ST_IDLE) && !w_fifo_empty;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state         <= ST_IDLE;
            r_gap_cnt       <= '0;
            r_scan_received <= 1'b0;
            r_scan          <= '0;
            r_extended      <= 1'b0;
            r_released      <= 1'b0;
        end else begin
            r_scan_received <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_scan          <= w_head.code;
                        r_extended      <= w_head.ext;
                        r_released      <= w_head.released;
                        r_scan_received <= 1'b1;
                        r_state         <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    r_gap_cnt <= c_gap_init;
                    r_state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_gap_one;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign scan_received = r_scan_received;
    assign scan          = r_scan;
    assign extended      = r_extended;
    assign released      = r_released;
    assign mega_pressed  = r_key_state[MEGA_KEY_IDX];
    assign overflow      = r_overflow;

endmodule : m65_matrix_to_scancode
`default_nettype wire

// File: tb/tb_m65_matrix_to_scancode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_m65_matrix_to_scancode
//  Description : Self-checking bench. A queue-based reference model predicts
//                every output each cycle from the key-event rules: events
//                join a queue on state changes of mapped keys, the emitter
//                takes the head when it is free and is busy for
//                GAP_CYCLES + 2 cycles per event.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m65_matrix_to_scancode;

    localparam int FIFO_DEPTH = 8;
    localparam int GAP_CYCLES = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       matrix_valid;
    logic [6:0] matrix_idx;
    logic       matrix_pressed;
    logic       scan_received;
    logic [6:0] scan;
    logic       extended;
    logic       released;
    logic       mega_pressed;
    logic       overflow;

    always #5 clk = ~clk;

    m65_matrix_to_scancode #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .matrix_valid   (matrix_valid),
        .matrix_idx     (matrix_idx),
        .matrix_pressed (matrix_pressed),
        .scan_received  (scan_received),
        .scan           (scan),
        .extended       (extended),
        .released       (released),
        .mega_pressed   (mega_pressed),
        .overflow       (overflow)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Keys the random stimulus draws from, with their standard set-2 codes.
    int pool [11] = '{1, 2, 7, 9, 10, 13, 15, 52, 56, 60, 62};

    // {mapped, ext, code}
    function automatic logic [8:0] ref_code(input int idx);
        case (idx)
            1:       return {2'b10, 7'h5A};  // RETURN -> Enter
            2:       return {2'b11, 7'h74};  // cursor right -> E0 74
            7:       return {2'b11, 7'h72};  // cursor down  -> E0 72
            9:       return {2'b10, 7'h1D};  // W
            10:      return {2'b10, 7'h1C};  // A
            13:      return {2'b10, 7'h1B};  // S
            15:      return {2'b10, 7'h12};  // left shift
            52:      return {2'b10, 7'h59};  // right shift
            56:      return {2'b10, 7'h16};  // 1
            60:      return {2'b10, 7'h29};  // space
            62:      return {2'b10, 7'h15};  // Q
            default: return 9'h000;
        endcase
    endfunction

    // ---------------- reference model ----------------
    bit         m_state [72];
    logic [8:0] m_q [$];          // {ext, code, released}
    int         m_cycle;
    int         m_free_at;        // first edge at which the emitter may take an event
    bit         e_sr;
    logic [6:0] e_scan;
    bit         e_ext;
    bit         e_rel;
    bit         e_ovf;

    task automatic model_reset();
        foreach (m_state[i]) m_state[i] = 1'b0;
        m_q.delete();
        m_cycle   = 0;
        m_free_at = 0;
        e_sr      = 1'b0;
        e_scan    = '0;
        e_ext     = 1'b0;
        e_rel     = 1'b0;
        e_ovf     = 1'b0;
    endtask

    // Predicts the outputs after the next rising edge.
    task automatic model_step(input bit valid, input int idx, input bit pressed);
        logic [8:0] ev;
        logic [8:0] ent;
        bit         take;
        m_cycle++;
        // An event pushed on this edge is not yet visible to the emitter.
        take = (m_q.size() > 0) && (m_cycle >= m_free_at);
        e_sr = take;
        if (take) begin
            ev        = m_q.pop_front();
            e_ext     = ev[8];
            e_scan    = ev[7:1];
            e_rel     = ev[0];
            m_free_at = m_cycle + GAP_CYCLES + 2;
        end
        if (valid && idx < 72 && pressed != m_state[idx]) begin
            m_state[idx] = pressed;
            ent = ref_code(idx);
            if (ent[8] && idx != 61) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back({ent[7], ent[6:0], ~pressed});
                else                         e_ovf = 1'b1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int         cyc_cnt   = 0;
    int         pulse_cnt = 0;
    int         pulse_at [$];
    logic [8:0] obs_log [$];

    function automatic logic [11:0] dut_outs();
        return {scan_received, scan, extended, released, mega_pressed, overflow};
    endfunction

    // Called at a falling edge: drive, let one rising edge pass, compare.
    task automatic cycle(input bit valid, input int idx, input bit pressed);
        matrix_valid   = valid;
        matrix_idx     = 7'(idx);
        matrix_pressed = pressed;
        model_step(valid, idx, pressed);
        @(negedge clk);
        cyc_cnt++;
        check_eq("outputs", dut_outs(), {e_sr, e_scan, e_ext, e_rel, m_state[61], e_ovf});
        if (scan_received) begin
            pulse_cnt++;
            pulse_at.push_back(cyc_cnt);
            obs_log.push_back({extended, scan, released});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((m_q.size() != 0 || m_cycle < m_free_at) && n < 400) begin
            cycle(1'b0, 0, 1'b0);
            n++;
        end
        check_eq(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic clear_log();
        pulse_cnt = 0;
        pulse_at.delete();
        obs_log.delete();
    endtask

    // Asserts reset mid-cycle, checks the immediate clear, then releases and
    // waits out the two synchroniser edges so the next cycle() is honoured.
    task automatic do_reset(input string tag);
        #2;
        rst_n        = 1'b0;
        matrix_valid = 1'b0;
        #1;
        check_eq(tag, 32'(dut_outs()), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_release", 32'(dut_outs()), 32'd0);
        clear_log();
    endtask

    task automatic random_phase(input int n, input int pct);
        int r;
        int idx;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 19);
            if (r < 16)      idx = pool[$urandom_range(0, 10)];
            else if (r < 18) idx = 61;
            else             idx = $urandom_range(72, 127);
            cycle($urandom_range(0, 99) < pct, idx, 1'($urandom_range(0, 1)));
        end
        drain("rand_drain");
    endtask

    // Eleven distinct keys and the make events they produce, in order.
    int         burst_keys [11] = '{10, 9, 13, 62, 56, 60, 1, 15, 52, 7, 2};
    logic [8:0] burst_ev   [11] = '{
        {1'b0, 7'h1C, 1'b0}, {1'b0, 7'h1D, 1'b0}, {1'b0, 7'h1B, 1'b0},
        {1'b0, 7'h15, 1'b0}, {1'b0, 7'h16, 1'b0}, {1'b0, 7'h29, 1'b0},
        {1'b0, 7'h5A, 1'b0}, {1'b0, 7'h12, 1'b0}, {1'b0, 7'h59, 1'b0},
        {1'b1, 7'h72, 1'b0}, {1'b1, 7'h74, 1'b0}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        matrix_valid   = 1'b0;
        matrix_idx     = '0;
        matrix_pressed = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset("rst_initial");

        // Press and release A: first pulse two cycles after the strobe.
        cycle(1'b1, 10, 1'b1);
        check_eq("a_lat_n1", 32'(scan_received), 32'd0);
        cycle(1'b0, 0, 1'b0);
        check_eq("a_lat_n2", 32'({scan_received, extended, scan, released}),
                 32'({1'b1, 1'b0, 7'h1C, 1'b0}));
        cycle(1'b1, 10, 1'b0);
        drain("a_drain");
        check_eq("a_count", 32'(pulse_cnt), 32'd2);
        if (pulse_cnt == 2) begin
            check_eq("a_break", 32'(obs_log[1]), 32'({1'b0, 7'h1C, 1'b1}));
            check_eq("a_spacing", 32'(pulse_at[1] - pulse_at[0] >= GAP_CYCLES), 32'd1);
        end

        // Extended key.
        clear_log();
        cycle(1'b1, 7, 1'b1);
        drain("b_drain");
        check_eq("b_count", 32'(pulse_cnt), 32'd1);
        check_eq("b_event", 32'({extended, scan, released}), 32'({1'b1, 7'h72, 1'b0}));

        // MEGA key: level only, never an event.
        clear_log();
        cycle(1'b1, 61, 1'b1);
        check_eq("mega_on", 32'(mega_pressed), 32'd1);
        idle(10);
        cycle(1'b1, 61, 1'b0);
        check_eq("mega_off", 32'(mega_pressed), 32'd0);
        idle(4);
        check_eq("mega_no_pulse", 32'(pulse_cnt), 32'd0);

        // Duplicate press of A (still up from before -> press once first)
        // and an out-of-range index produce nothing.
        cycle(1'b1, 10, 1'b1);
        drain("d_drain");
        clear_log();
        cycle(1'b1, 10, 1'b1);
        cycle(1'b1, 100, 1'b1);
        cycle(1'b1, 100, 1'b0);
        idle(12);
        check_eq("dup_no_pulse", 32'(pulse_cnt), 32'd0);
        cycle(1'b1, 10, 1'b0);
        drain("d_rel_drain");
        check_eq("dup_state_kept", 32'(obs_log.size() == 1 && obs_log[0] == {1'b0, 7'h1C, 1'b1}), 32'd1);

        // Nine back-to-back presses fit: the first is taken on the second
        // strobe's edge, leaving eight queued after the ninth.
        do_reset("rst_burst9");
        for (int i = 0; i < 9; i++) cycle(1'b1, burst_keys[i], 1'b1);
        check_eq("burst9_no_ovf", 32'(overflow), 32'd0);
        drain("burst9_drain");
        check_eq("burst9_count", 32'(pulse_cnt), 32'd9);
        for (int i = 0; i < 9 && i < obs_log.size(); i++)
            check_eq("burst9_order", 32'(obs_log[i]), 32'(burst_ev[i]));

        // Tenth push meets a full FIFO on the same edge as the next take and
        // is accepted; the eleventh finds it full with no take and is lost.
        do_reset("rst_burst11");
        for (int i = 0; i < 10; i++) cycle(1'b1, burst_keys[i], 1'b1);
        check_eq("burst10_no_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, burst_keys[10], 1'b1);
        check_eq("burst11_ovf", 32'(overflow), 32'd1);
        drain("burst11_drain");
        check_eq("burst11_count", 32'(pulse_cnt), 32'd10);
        if (obs_log.size() == 10) check_eq("burst11_last", 32'(obs_log[9]), 32'(burst_ev[9]));

        // Reset while in the gap with three events still queued.
        do_reset("rst_pre_gap");
        for (int i = 0; i < 4; i++) cycle(1'b1, burst_keys[i], 1'b1);
        idle(2);
        check_eq("gap_pulsed", 32'(pulse_cnt), 32'd1);
        do_reset("rst_in_gap");
        idle(40);
        check_eq("gap_no_pulse", 32'(pulse_cnt), 32'd0);

        // Randomised traffic at three strobe densities.
        do_reset("rst_rand_lo");
        random_phase(600, 15);
        do_reset("rst_rand_mid");
        random_phase(600, 45);
        do_reset("rst_rand_hi");
        random_phase(600, 90);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_m65_matrix_to_scancode
`default_nettype wire
